// File: rtl/tetris_input_conditioner.sv
// tetris_input_conditioner
//   Turns six raw active-low push buttons into clean pulses and levels for the
//   Tetris processor. Every button goes through a 2-flop synchroniser and a
//   debouncer. Five channels become fixed-width action pulses. fast_move
//   becomes a held level.
//
//   Optional feature macro: TETRIS_AUTOREPEAT_EN
//     defined   -> move_left / move_right auto-repeat while held
//     undefined -> every pulse channel fires once per press and the repeat
//                  wait logic is compiled out
//
//   Ports
//     clk_clk        in   system clock
//     reset_reset_n  in   async active-low reset
//     btn_n[5:0]     in   raw buttons, active low:
//                         0 move_left, 1 move_right, 2 rotate_left,
//                         3 rotate_right, 4 fast_move, 5 reset_game
//     move_left_o    out  action pulse
//     move_right_o   out  action pulse
//     rotate_left_o  out  action pulse
//     rotate_right_o out  action pulse
//     fast_move_o    out  debounced held level, 1 = pressed
//     reset_game_o   out  action pulse

// Per-channel pulse generator.
// States: IDLE -> PULSE -> (WAIT_DELAY | WAIT_REPEAT) -> PULSE ...
module tetris_pulse_channel #(
  parameter int PULSE_CYCLES  = 50000,
  parameter int REPEAT_DELAY  = 15000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter bit AUTO_REPEAT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pressed,   // debounced level, 1 = pressed
  input  logic hold_off,  // both move buttons held: freeze the repeat wait
  output logic pulse
);
`ifdef TETRIS_AUTOREPEAT_EN
  localparam bit REP_ON = AUTO_REPEAT;
`else
  // Repeat compiled out: wait states are unreachable and the counter is
  // sized for the pulse width only.
  localparam bit REP_ON = AUTO_REPEAT & 1'b0;
`endif

  localparam int DELAY_W  = REPEAT_DELAY - PULSE_CYCLES;
  localparam int PERIOD_W = REPEAT_PERIOD - PULSE_CYCLES;
  localparam int WAIT_MAX = (DELAY_W > PERIOD_W) ? DELAY_W : PERIOD_W;
  localparam int CMAX     = (REP_ON && WAIT_MAX > PULSE_CYCLES) ? WAIT_MAX : PULSE_CYCLES;
  localparam int CW       = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(DELAY_W - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD_W - 1);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] PULSE       = 2'd1;
  localparam logic [1:0] WAIT_DELAY  = 2'd2;
  localparam logic [1:0] WAIT_REPEAT = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          pressed_d;
  logic          repeating;  // current pulse is an auto-repeat, not the first
  logic [CW-1:0] wait_last;

  assign wait_last = (state == WAIT_DELAY) ? DELAY_LAST : PERIOD_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pressed_d <= 1'b0;
      repeating <= 1'b0;
    end else begin
      pressed_d <= pressed;
      case (state)
        IDLE: begin
          cnt <= '0;
          // presses seen in any other state are dropped
          if (pressed && !pressed_d) begin
            state     <= PULSE;
            repeating <= 1'b0;
          end
        end
        PULSE: begin
          // a pulse always runs its full width, release or not
          if (cnt == PULSE_LAST) begin
            cnt <= '0;
            if (REP_ON && pressed) state <= repeating ? WAIT_REPEAT : WAIT_DELAY;
            else                   state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DELAY, WAIT_REPEAT: begin
          if (!pressed) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (hold_off) begin
            cnt <= '0;
          end else if (cnt == wait_last) begin
            state     <= PULSE;
            cnt       <= '0;
            repeating <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign pulse = (state == PULSE);
endmodule

module tetris_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_CYCLES    = 50000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [5:0] btn_n,
  output logic       move_left_o,
  output logic       move_right_o,
  output logic       rotate_left_o,
  output logic       rotate_right_o,
  output logic       fast_move_o,
  output logic       reset_game_o
);
  localparam int NUM_BTN = 6;
  localparam int NUM_CH  = 5;
  localparam int DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0]         sync1, sync2;
  logic [NUM_BTN-1:0]         pressed;  // debounced, 1 = pressed
  logic [NUM_BTN-1:0][DW-1:0] db_cnt;
  logic [NUM_CH-1:0]          pulse;

  // Synchronisers reset to the released level so a button held through
  // reset is seen as a fresh press afterwards.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // sync2 is active low, so sync2 != pressed means the synchronised level
  // agrees with the debounced state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pressed <= '0;
      db_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] != pressed[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          pressed[i] <= ~pressed[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Channel g drives button g, except the last channel which serves
  // reset_game (button 5); button 4 is a level, not a pulse.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam int B = (g == NUM_CH - 1) ? 5 : g;
    tetris_pulse_channel #(
      .PULSE_CYCLES (PULSE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .AUTO_REPEAT  (g < 2)
    ) u_ch (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .pressed (pressed[B]),
      .hold_off(pressed[0] & pressed[1]),
      .pulse   (pulse[g])
    );
  end

  assign move_left_o    = pulse[0];
  assign move_right_o   = pulse[1];
  assign rotate_left_o  = pulse[2];
  assign rotate_right_o = pulse[3];
  assign reset_game_o   = pulse[4];
  assign fast_move_o    = pressed[4];
endmodule

// File: tb/tb_tetris_input_conditioner.sv
// Bench for tetris_input_conditioner with small timing parameters.
// A cycle-level reference built from countdowns, timestamps and a sample
// window is checked against the DUT on every negative clock edge; directed
// scenarios add literal timing expectations.
module tb_tetris_input_conditioner;
  localparam int D = 4, P = 3, RD = 20, RP = 8;
`ifdef TETRIS_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b1;
  logic [5:0] btn_n = '1;
  logic move_left_o, move_right_o, rotate_left_o, rotate_right_o, fast_move_o, reset_game_o;

  always #5 clk_clk = ~clk_clk;

  tetris_input_conditioner #(
    .DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .btn_n(btn_n),
    .move_left_o(move_left_o), .move_right_o(move_right_o),
    .rotate_left_o(rotate_left_o), .rotate_right_o(rotate_right_o),
    .fast_move_o(fast_move_o), .reset_game_o(reset_game_o)
  );

  wire [5:0] dut_out = {reset_game_o, fast_move_o, rotate_right_o,
                        rotate_left_o, move_right_o, move_left_o};

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model ----------------
  logic [5:0] m_s1, m_s2, m_deb, m_deb_d, exp_out;
  logic [5:0] m_lh [D];          // last D synchronised pressed-levels
  int  m_pl [6];                 // pulse cycles still to output
  int  m_wl [6];                 // wait cycles before next repeat
  int  m_wfull [6];              // wait length to restart from when frozen
  bit  m_first [6];

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_deb = '0; m_deb_d = '0; exp_out = '0;
    for (int i = 0; i < D; i++) m_lh[i] = '0;
    for (int i = 0; i < 6; i++) begin
      m_pl[i] = 0; m_wl[i] = 0; m_wfull[i] = 0; m_first[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [5:0] lvl;
    bit both, held, press, flip;
    int b;
    lvl  = ~m_s2;
    both = m_deb[0] && m_deb[1];
    for (int c = 0; c < 5; c++) begin
      b = (c == 4) ? 5 : c;
      held  = m_deb[b];
      press = m_deb[b] && !m_deb_d[b];
      if (m_pl[b] > 0) begin
        m_pl[b]--;
        if (m_pl[b] == 0 && AUTOREP && b < 2 && held) begin
          m_wfull[b] = m_first[b] ? RD - P : RP - P;
          m_wl[b] = m_wfull[b];
          m_first[b] = 1'b0;
        end
      end else if (m_wl[b] > 0) begin
        if (!held) m_wl[b] = 0;
        else if (both) m_wl[b] = m_wfull[b];
        else begin
          m_wl[b]--;
          if (m_wl[b] == 0) m_pl[b] = P;
        end
      end else if (press) begin
        m_pl[b] = P;
        m_first[b] = 1'b1;
      end
    end
    m_deb_d = m_deb;
    for (int i = D - 1; i > 0; i--) m_lh[i] = m_lh[i-1];
    m_lh[0] = lvl;
    for (int k = 0; k < 6; k++) begin
      flip = 1'b1;
      for (int i = 0; i < D; i++) if (m_lh[i][k] == m_deb[k]) flip = 1'b0;
      if (flip) m_deb[k] = ~m_deb[k];
    end
    m_s2 = m_s1;
    m_s1 = btn_n;
    for (int k = 0; k < 6; k++) exp_out[k] = (m_pl[k] > 0);
    exp_out[4] = m_deb[4];
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_clk or negedge reset_reset_n);
      if (!reset_reset_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk_clk);
      if (chk_en) begin
        checks++;
        if (dut_out !== exp_out) begin
          failures++;
          $display("FAIL model_cmp t=%0t got=%b want=%b", $time, dut_out, exp_out);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  int wk;
  int rise_n [6];
  int rise_t [6][16];
  int highs [6];
  logic [5:0] prev;

  task automatic watch_start();
    wk = 0;
    prev = dut_out;
    for (int i = 0; i < 6; i++) begin rise_n[i] = 0; highs[i] = 0; end
  endtask

  // wk = index of the clock edge after the stimulus point
  task automatic watch(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      @(negedge clk_clk);
      wk++;
      for (int i = 0; i < 6; i++) begin
        if (dut_out[i]) highs[i]++;
        if (dut_out[i] && !prev[i]) begin
          if (rise_n[i] < 16) rise_t[i][rise_n[i]] = wk;
          rise_n[i]++;
        end
      end
      prev = dut_out;
    end
  endtask

  task automatic settle();
    btn_n = '1;
    repeat (30) @(negedge clk_clk);
  endtask

  int rep_exp [6] = '{7, 27, 35, 43, 51, 59};
  int nrep;
  int idx;

  initial begin
    #1 reset_reset_n = 1'b0;
    repeat (3) @(negedge clk_clk);
    chk_en = 1'b1;
    chk("reset_outputs", int'(dut_out), 0);
    #2 reset_reset_n = 1'b1;
    settle();

    // short glitch is filtered
    watch_start();
    btn_n[2] = 1'b0;
    watch(3);
    btn_n[2] = 1'b1;
    watch(15);
    chk("glitch_rises", rise_n[2], 0);
    chk("glitch_highs", highs[2], 0);
    settle();

    // single rotate pulse, 7 cycles after the fall, 3 wide
    watch_start();
    btn_n[2] = 1'b0;
    watch(100);
    btn_n[2] = 1'b1;
    watch(20);
    chk("rot_rises", rise_n[2], 1);
    chk("rot_first_rise", rise_t[2][0], 7);
    chk("rot_width", highs[2], 3);
    settle();

    // held move_left: auto-repeat when enabled
    watch_start();
    btn_n[0] = 1'b0;
    watch(60);
    btn_n[0] = 1'b1;
    watch(30);
    nrep = AUTOREP ? 6 : 1;
    chk("hold_rises", rise_n[0], nrep);
    for (int i = 0; i < nrep && i < rise_n[0]; i++) chk("hold_rise_time", rise_t[0][i], rep_exp[i]);
    chk("hold_highs", highs[0], 3 * nrep);
    settle();

    // both moves held: no repeats
    watch_start();
    btn_n[1:0] = 2'b00;
    watch(60);
    btn_n[1:0] = 2'b11;
    watch(30);
    chk("both_rises_l", rise_n[0], 1);
    chk("both_rises_r", rise_n[1], 1);
    chk("both_rise_t_l", rise_t[0][0], 7);
    chk("both_rise_t_r", rise_t[1][0], 7);
    settle();

    // release one cycle into the pulse: full width, nothing after
    watch_start();
    btn_n[0] = 1'b0;
    watch(7);
    btn_n[0] = 1'b1;
    watch(40);
    chk("rel_rises", rise_n[0], 1);
    chk("rel_width", highs[0], 3);
    settle();

    // async reset mid-pulse, fast_move held through it
    watch_start();
    btn_n[0] = 1'b0;
    btn_n[4] = 1'b0;
    watch(8);
    chk("mid_pulse_high", int'(move_left_o), 1);
    #2 reset_reset_n = 1'b0;
    #1 chk("reset_async_zero", int'(dut_out), 0);
    @(negedge clk_clk);
    watch_start();
    #2 reset_reset_n = 1'b1;
    watch(10);
    chk("fast_rises", rise_n[4], 1);
    chk("fast_rise_time", rise_t[4][0], 6);
    chk("fast_highs", highs[4], 5);
    chk("post_reset_press", rise_t[0][0], 7);
    settle();

    // randomized traffic against the model
    for (int seg = 0; seg < 200; seg++) begin
      if ($urandom_range(0, 3) == 0) btn_n = 6'($urandom);
      else begin
        idx = $urandom_range(0, 5);
        btn_n[idx] = ~btn_n[idx];
      end
      if ($urandom_range(0, 39) == 0) begin
        #2 reset_reset_n = 1'b0;
        @(negedge clk_clk);
        #2 reset_reset_n = 1'b1;
      end
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(30, 60)) @(negedge clk_clk);
      else repeat ($urandom_range(1, 25)) @(negedge clk_clk);
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tetris_input_conditioner.md
TETRIS_INPUT_CONDITIONER -- requirements
Module: tetris_input_conditioner

Interface
REQ-001 The parameters SHALL be, one per line:
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a raw level change.
- PULSE_CYCLES, default 50000: width of each action pulse.
- REPEAT_DELAY, default 15000000: cycles from accepted press to first auto-repeat pulse.
- REPEAT_PERIOD, default 5000000: cycles between auto-repeat pulses; SHALL exceed PULSE_CYCLES.
REQ-002 The ports SHALL be, one per line:
- clk_clk, input, 1: single system clock.
- reset_reset_n, input, 1: asynchronous, active-low reset.
- btn_n, input, 6: raw active-low buttons. Bit 0 move_left, 1 move_right, 2 rotate_left, 3 rotate_right, 4 fast_move, 5 reset_game.
- move_left_o, output, 1: conditioned pulse to the processor move-left input.
- move_right_o, output, 1: conditioned pulse to the processor move-right input.
- rotate_left_o, output, 1: conditioned pulse to the processor rotate-left input.
- rotate_right_o, output, 1: conditioned pulse to the processor rotate-right input.
- fast_move_o, output, 1: debounced held level, 1 = pressed.
- reset_game_o, output, 1: conditioned pulse to the processor game-reset input.

Function
REQ-003 Each btn_n bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-004 Each channel SHALL hold a debounced state, reset value "released". Every cycle in which the synchronised level equals the debounced state SHALL clear that channel's counter. Otherwise the counter SHALL increment, and on reaching DEBOUNCE_CYCLES-1 the debounced state SHALL flip and the counter SHALL clear.
REQ-005 The latency from a stable raw change to an accepted change SHALL be 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES SHALL produce no output.
REQ-006 fast_move_o SHALL equal the debounced pressed state of bit 4, registered.
REQ-007 Every pulse channel (bits 0,1,2,3,5) SHALL run a state machine with states IDLE, PULSE, WAIT_DELAY, WAIT_REPEAT.
REQ-008 IDLE -> PULSE on an accepted press. The output SHALL rise the cycle after the accepted press and stay high for exactly PULSE_CYCLES cycles.
REQ-009 At the end of PULSE, the next state SHALL be:
- WAIT_DELAY, if the button is still held and this was the first pulse;
- WAIT_REPEAT, if the button is still held and this was a repeat pulse;
- IDLE, if the button has been released.
REQ-010 WAIT_DELAY -> PULSE after REPEAT_DELAY-PULSE_CYCLES cycles, so the first repeat rises REPEAT_DELAY cycles after the first pulse rose.
REQ-011 WAIT_REPEAT -> PULSE after REPEAT_PERIOD-PULSE_CYCLES cycles.
REQ-012 An accepted release SHALL return the channel to IDLE from WAIT_DELAY or WAIT_REPEAT immediately. A pulse already in progress SHALL always complete its full width and SHALL never be truncated.
REQ-013 Only move_left and move_right auto-repeat. rotate_left, rotate_right and reset_game SHALL go PULSE -> IDLE and produce exactly one pulse per accepted press.
REQ-014 While move_left and move_right are both debounced-pressed, neither channel SHALL start a repeat pulse; it SHALL hold its wait counter at zero. Initial press pulses are unaffected.
REQ-015 A new press accepted while a channel is not in IDLE SHALL NOT start an extra pulse.
REQ-016 Counters SHALL be sized by clog2 of their maximum count and SHALL never wrap.

Reset
REQ-017 Asserting reset_reset_n low SHALL, asynchronously:
- force all outputs to 0;
- set synchroniser flops to 1 (released);
- set debounced states to released;
- clear all counters and return every state machine to IDLE.
REQ-018 After deassertion, a button already held SHALL be treated as a new press and accepted after 2 + DEBOUNCE_CYCLES cycles.

Configuration
REQ-019 Macro TETRIS_AUTOREPEAT_EN:
- When defined, REQ-009 to REQ-011 and REQ-014 apply to move_left and move_right.
- When undefined, all pulse channels behave as in REQ-013 (one pulse per press), and the repeat counters SHALL not be synthesised.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-020 The bench SHALL cover these directed scenarios:
- A 3-cycle low glitch on btn_n[2] -> rotate_left_o stays 0.
- btn_n[2] low for 100 cycles -> rotate_left_o high for exactly 3 cycles, starting 7 cycles after the fall; exactly one pulse.
- btn_n[0] held 60 cycles with TETRIS_AUTOREPEAT_EN -> move_left_o pulses rise at t0, t0+20, t0+28, t0+36, t0+44, t0+52. Without the macro -> only t0.
- btn_n[0] and btn_n[1] pressed together and held 60 cycles -> one pulse each, no repeats.
- btn_n[0] released 1 cycle into a pulse -> pulse still 3 cycles wide, then no further pulses.
- reset_reset_n pulsed low mid-pulse -> all outputs 0 in the same cycle; with btn_n[4] held, fast_move_o rises 6 cycles after deassertion.
